// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_tx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = !clear && (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a registered-output synchronous FIFO.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastData = IdxW'(DATA_WIDTH - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

    uart_tx_state_t        state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [IdxW-1:0]       bit_idx_q;
    logic                  parity_q;
    logic                  rd_en_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  tx_done_q;
    logic                  bit_tick;
    logic                  baud_clear;

    // The divider only runs while a bit is on the line.
    assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            tx_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The strobe is issued while still idle; FETCH follows it.
                    if (rd_en_q) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end else if (enable && !fifo_empty) begin
                        rd_en_q <= 1'b1;
                    end
                end
                FETCH: begin
                    shreg_q  <= fifo_data;
                    parity_q <= ^fifo_data;
                    tx_q     <= START_LEVEL;
                    state_q  <= START;
                end
                START: begin
                    if (bit_tick) begin
                        tx_q      <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LastData) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= STOP_LEVEL;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                            tx_q      <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_q      <= STOP_LEVEL;
                        bit_idx_q <= '0;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LastStop) begin
                            bit_idx_q <= '0;
                            tx_q      <= IDLE_LEVEL;
                            busy_q    <= 1'b0;
                            tx_done_q <= 1'b1;
                            state_q   <= IDLE;
                            // Pre-issue the next read so frames run back to back.
                            rd_en_q   <= enable && !fifo_empty;
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitter configurations, each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       en      [3];
    logic       empty   [3];
    logic [7:0] data    [3];
    logic       rd_en   [3];
    logic       tx      [3];
    logic       busy    [3];
    logic       done    [3];

    logic [7:0] mem     [3][16];
    int         wrp     [3];
    int         rdp     [3];
    bit         bad_rd  [3];

    int n_assert;
    int n_fail;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_basic (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(data[0]),
        .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut_par (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(data[1]),
        .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1])
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(data[2]),
        .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i] === 1'b1) begin
                if (empty[i]) bad_rd[i] <= 1'b1;
                data[i] <= mem[i][rdp[i] % 16];
                rdp[i]  <= rdp[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i] = (wrp[i] == rdp[i]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wrp[k] % 16] = b;
        wrp[k] = wrp[k] + 1;
    endtask

    task automatic wait_rd(input int k, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rd_en[k] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk($sformatf("k%0d wait_rd", k), {31'd0, found}, 32'd1);
    endtask

    // Entered at the cycle the read strobe is high; checks every line cycle of the frame.
    task automatic check_frame(input int k, input logic [7:0] b, input int par, input int stops,
                               input logic next_rd);
        logic lv [12];
        int   n;
        n = 0;
        lv[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < 8; i++) begin
            lv[n] = b[i];
            n = n + 1;
        end
        if (par != 0) begin
            lv[n] = ^b;
            n = n + 1;
        end
        for (int s = 0; s < stops; s++) begin
            lv[n] = 1'b1;
            n = n + 1;
        end
        chk($sformatf("k%0d %02h rd_pulse", k, b), {31'd0, rd_en[k]}, 32'd1);
        chk($sformatf("k%0d %02h busy_at_rd", k, b), {31'd0, busy[k]}, 32'd0);
        tick();
        chk($sformatf("k%0d %02h rd_single", k, b), {31'd0, rd_en[k]}, 32'd0);
        chk($sformatf("k%0d %02h busy_fetch", k, b), {31'd0, busy[k]}, 32'd1);
        chk($sformatf("k%0d %02h tx_fetch", k, b), {31'd0, tx[k]}, 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("k%0d %02h bit%0d c%0d tx", k, b, i, c), {31'd0, tx[k]},
                    {31'd0, lv[i]});
                if (i == n - 1 && c == 3) begin
                    chk($sformatf("k%0d %02h done_early", k, b), {31'd0, done[k]}, 32'd0);
                end
            end
        end
        tick();
        chk($sformatf("k%0d %02h tx_done", k, b), {31'd0, done[k]}, 32'd1);
        chk($sformatf("k%0d %02h busy_end", k, b), {31'd0, busy[k]}, 32'd0);
        chk($sformatf("k%0d %02h tx_end", k, b), {31'd0, tx[k]}, 32'd1);
        chk($sformatf("k%0d %02h next_rd", k, b), {31'd0, rd_en[k]}, {31'd0, next_rd});
        if (!next_rd) begin
            tick();
            chk($sformatf("k%0d %02h done_single", k, b), {31'd0, done[k]}, 32'd0);
        end
    endtask

    initial begin
        int rd_seen;
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("k%0d reset tx", i), {31'd0, tx[i]}, 32'd1);
            chk($sformatf("k%0d reset busy", i), {31'd0, busy[i]}, 32'd0);
            chk($sformatf("k%0d reset rd_en", i), {31'd0, rd_en[i]}, 32'd0);
            chk($sformatf("k%0d reset tx_done", i), {31'd0, done[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle with empty FIFO, then with data but enable low.
        rd_seen = 0;
        repeat (5) begin
            tick();
            if (rd_en[0] !== 1'b0 || tx[0] !== 1'b1) rd_seen++;
        end
        chk("idle_empty", rd_seen, 0);
        push(0, 8'hA5);
        rd_seen = 0;
        repeat (5) begin
            tick();
            if (rd_en[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) rd_seen++;
        end
        chk("idle_disabled", rd_seen, 0);

        // Basic 8N1 frame.
        en[0] = 1'b1;
        wait_rd(0, 5);
        check_frame(0, 8'hA5, 0, 1, 1'b0);
        rd_seen = 0;
        repeat (10) begin
            tick();
            if (rd_en[0] !== 1'b0) rd_seen++;
        end
        chk("idle_after_basic", rd_seen, 0);

        // Back-to-back frames: second strobe lands 42 cycles after the first.
        push(0, 8'h11);
        push(0, 8'h22);
        wait_rd(0, 5);
        check_frame(0, 8'h11, 0, 1, 1'b1);
        check_frame(0, 8'h22, 0, 1, 1'b0);
        rd_seen = 0;
        repeat (50) begin
            tick();
            if (rd_en[0] !== 1'b0) rd_seen++;
        end
        chk("no_rd_when_empty", rd_seen, 0);

        // Enable dropped mid-frame: frame completes, next fetch waits for enable.
        push(0, 8'h33);
        push(0, 8'h44);
        wait_rd(0, 5);
        fork
            check_frame(0, 8'h33, 0, 1, 1'b0);
            begin
                repeat (10) @(posedge clk);
                en[0] = 1'b0;
            end
        join
        rd_seen = 0;
        repeat (20) begin
            tick();
            if (rd_en[0] !== 1'b0) rd_seen++;
        end
        chk("no_rd_while_disabled", rd_seen, 0);
        en[0] = 1'b1;
        wait_rd(0, 5);
        check_frame(0, 8'h44, 0, 1, 1'b0);

        // Even parity: 0x07 -> 1, 0x03 -> 0, frames 46 cycles apart.
        push(1, 8'h07);
        push(1, 8'h03);
        en[1] = 1'b1;
        wait_rd(1, 5);
        check_frame(1, 8'h07, 1, 1, 1'b1);
        check_frame(1, 8'h03, 1, 1, 1'b0);

        // Two stop bits: 8 high cycles, strobes 46 cycles apart.
        push(2, 8'hFF);
        push(2, 8'h00);
        en[2] = 1'b1;
        wait_rd(2, 5);
        check_frame(2, 8'hFF, 0, 2, 1'b1);
        check_frame(2, 8'h00, 0, 2, 1'b0);

        // Reset during DATA: line returns high without a clock edge.
        push(0, 8'h81);
        wait_rd(0, 5);
        repeat (10) tick();
        chk("pre_reset busy", {31'd0, busy[0]}, 32'd1);
        chk("pre_reset tx_bit1", {31'd0, tx[0]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset tx", {31'd0, tx[0]}, 32'd1);
        chk("async_reset busy", {31'd0, busy[0]}, 32'd0);
        chk("async_reset rd_en", {31'd0, rd_en[0]}, 32'd0);
        push(0, 8'h3C);
        @(negedge clk);
        rst_n = 1'b1;
        wait_rd(0, 5);
        check_frame(0, 8'h3C, 0, 1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("k%0d rd_while_empty", i), {31'd0, bad_rd[i]}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
